// File: rtl/sipo_shift_reg_pkg.sv
// Shared definitions for the serial-in, parallel-out shift register.
// Users of the parallel word can size their datapath from sipo_word_t.
package sipo_shift_reg_pkg;

    localparam int SIPO_WIDTH = 4;

    typedef logic [SIPO_WIDTH-1:0] sipo_word_t;

endpackage : sipo_shift_reg_pkg

// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register: one bit enters at the LSB every clock,
// the oldest bit falls off the MSB, and po mirrors the register directly.
module sipo_shift_reg
    import sipo_shift_reg_pkg::*;
#(
    parameter int               WIDTH       = SIPO_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // No enable: every non-reset edge shifts, discarding the old MSB.
    assign q_d = {q_q[WIDTH-2:0], si};

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign po = q_q;

endmodule : sipo_shift_reg

// File: tb/tb_sipo_shift_reg.sv
// Scoreboard bench for sipo_shift_reg at WIDTH=4 (default reset) and WIDTH=8
// (non-zero reset value), sharing one serial stream and reset.
module tb_sipo_shift_reg;

    logic       clk;
    logic       rst;
    logic       si;
    logic [3:0] po4;
    logic [7:0] po8;

    localparam logic [7:0] RV8 = 8'h3C;

    int total;
    int bad;

    logic [3:0] exp4_q[$];
    logic [7:0] exp8_q[$];

    // Reference state held as plain integers: reset loads the reset value,
    // otherwise value = (2*value + si) mod 2^WIDTH.
    int m4;
    int m8;

    sipo_shift_reg #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .si  (si),
        .po  (po4)
    );

    sipo_shift_reg #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .si  (si),
        .po  (po8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs; expected words go to the scoreboard queues.
    // A directed value (d4/d8 set) overrides the model's prediction.
    task automatic step(input logic r, input logic s,
                        input bit d4, input logic [3:0] e4,
                        input bit d8, input logic [7:0] e8);
        rst = r;
        si  = s;
        if (r) begin
            m4 = 0;
            m8 = int'(RV8);
        end else begin
            m4 = (m4 * 2 + int'(s)) % 16;
            m8 = (m8 * 2 + int'(s)) % 256;
        end
        exp4_q.push_back(d4 ? e4 : 4'(m4));
        exp8_q.push_back(d8 ? e8 : 8'(m8));
        @(negedge clk);
    endtask

    task automatic step4(input logic r, input logic s, input logic [3:0] e4);
        step(r, s, 1'b1, e4, 1'b0, 8'h00);
    endtask

    // Monitor: after every rising edge, compare outputs with queued expectations.
    always @(posedge clk) begin
        #1;
        if (exp4_q.size() > 0) begin
            logic [3:0] e;
            e = exp4_q.pop_front();
            total++;
            if (po4 !== e) begin
                bad++;
                $display("FAIL po_w4 at %0t: got %b expected %b", $time, po4, e);
            end
        end
        if (exp8_q.size() > 0) begin
            logic [7:0] e;
            e = exp8_q.pop_front();
            total++;
            if (po8 !== e) begin
                bad++;
                $display("FAIL po_w8 at %0t: got %h expected %h", $time, po8, e);
            end
        end
    end

    initial begin
        logic [7:0] word;
        logic [3:0] seq_a;
        logic [3:0] exp_a[4];
        total = 0;
        bad   = 0;
        m4    = 0;
        m8    = 0;
        rst   = 1'b1;
        si    = 1'b1;

        // Reset with si high, then held for three more edges.
        step4(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) step4(1'b1, 1'($urandom_range(0, 1)), 4'b0000);

        // Serial load 1,0,1,1.
        seq_a = 4'b1011;
        exp_a = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        for (int i = 0; i < 4; i++) step4(1'b0, seq_a[3-i], exp_a[i]);

        // Flush with zeros.
        exp_a = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) step4(1'b0, 1'b0, exp_a[i]);

        // All ones, overflowing past the MSB.
        step4(1'b0, 1'b1, 4'b0001);
        step4(1'b0, 1'b1, 4'b0011);
        step4(1'b0, 1'b1, 4'b0111);
        for (int i = 0; i < 3; i++) step4(1'b0, 1'b1, 4'b1111);

        // Reach 0101, then reset mid-stream with si high, then resume.
        step4(1'b1, 1'b0, 4'b0000);
        step4(1'b0, 1'b0, 4'b0000);
        step4(1'b0, 1'b1, 4'b0001);
        step4(1'b0, 1'b0, 4'b0010);
        step4(1'b0, 1'b1, 4'b0101);
        step4(1'b1, 1'b1, 4'b0000);
        step4(1'b0, 1'b1, 4'b0001);

        // Eight-bit word A5, MSB first, then one more zero.
        word = 8'hA5;
        for (int i = 0; i < 7; i++) step(1'b0, word[7-i], 1'b0, 4'h0, 1'b0, 8'h00);
        step(1'b0, word[0], 1'b0, 4'h0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h4A);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 1'b0, 4'h0, 1'b0, 8'h00);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && (exp4_q.size() > 0 || exp8_q.size() > 0); i++) begin
            @(negedge clk);
        end
        if (exp4_q.size() > 0 || exp8_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", exp4_q.size(), exp8_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sipo_shift_reg
